uart_tx_rr_sched: RTL and testbench

- Round-robin scheduler sharing one soft-UART byte transmitter among NUM_REQ requesters.
- Accepts one byte per grant over a valid/ready handshake.
- Optionally prefixes the byte with a requester-ID header byte.
- Sequences the transmitter through a start/busy handshake and enforces an idle gap between frames; sits between on-chip byte producers and the shared UART TX shifter.

---
 rtl/uart_tx_rr_sched.sv | 148 ++++++++++++++
 tb/tb_uart_tx_rr_sched.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_rr_sched.sv
// Round-robin scheduler sharing one UART byte transmitter among four requesters.
// Optionally prefixes each payload byte with an ID header and enforces an idle gap between frames.
module uart_tx_rr_sched #(
   parameter int NUM_REQ   = 4,
   parameter bit HDR_EN    = 1'b1,
   parameter int GAP_TICKS = 5208
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic [NUM_REQ-1:0]     i_req_valid,
   input  logic [8*NUM_REQ-1:0]   i_req_data,
   output logic [NUM_REQ-1:0]     o_req_ready,
   output logic                   o_tx_start,
   output logic [7:0]             o_tx_data,
   input  logic                   i_tx_busy,
   output logic [1:0]             o_grant_id,
   output logic                   o_sched_busy,
   output logic [15:0]            o_sent_count
);

   localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
   localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

   typedef enum logic [3:0] {
      S_IDLE, S_ARB, S_HDR, S_HW_HI, S_HW_LO, S_DATA, S_DW_HI, S_DW_LO, S_GAP
   } state_t;

   state_t              r_state, w_state_nxt;
   logic [1:0]          r_rr_ptr, w_rr_nxt;
   logic [1:0]          r_grant_id, w_grant_nxt;
   logic [7:0]          r_hold, w_hold_nxt;
   logic [NUM_REQ-1:0]  r_req_ready, w_ready_nxt;
   logic                r_tx_start, w_start_nxt;
   logic [7:0]          r_tx_data, w_txd_nxt;
   logic                r_sched_busy, w_sbusy_nxt;
   logic [15:0]         r_sent_count, w_sent_nxt;
   logic [GW-1:0]       r_gap_cnt, w_gap_nxt;

   logic                w_found;
   logic [1:0]          w_pick;
   logic [1:0]          w_cand;

   // First valid requester at or after rr_ptr, wrapping modulo four.
   always_comb begin
      w_found = 1'b0;
      w_pick  = r_rr_ptr;
      w_cand  = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         w_cand = r_rr_ptr + k[1:0];
         if (!w_found && i_req_valid[w_cand]) begin
            w_found = 1'b1;
            w_pick  = w_cand;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_rr_nxt    = r_rr_ptr;
      w_grant_nxt = r_grant_id;
      w_hold_nxt  = r_hold;
      w_ready_nxt = '0;
      w_start_nxt = 1'b0;
      w_txd_nxt   = r_tx_data;
      w_sent_nxt  = r_sent_count;
      w_gap_nxt   = r_gap_cnt;
      case (r_state)
         S_IDLE: begin
            if (|i_req_valid) w_state_nxt = S_ARB;
         end
         S_ARB: begin
            if (w_found) begin
               w_grant_nxt         = w_pick;
               w_hold_nxt          = i_req_data[8*w_pick +: 8];
               w_ready_nxt[w_pick] = 1'b1;
               w_rr_nxt            = w_pick + 2'd1;
               w_state_nxt         = HDR_EN ? S_HDR : S_DATA;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_HDR: begin
            w_txd_nxt   = 8'hA0 | {6'd0, r_grant_id};
            w_start_nxt = 1'b1;
            w_state_nxt = S_HW_HI;
         end
         S_HW_HI: if (i_tx_busy)  w_state_nxt = S_HW_LO;
         S_HW_LO: if (!i_tx_busy) w_state_nxt = S_DATA;
         S_DATA: begin
            w_txd_nxt   = r_hold;
            w_start_nxt = 1'b1;
            w_state_nxt = S_DW_HI;
         end
         S_DW_HI: if (i_tx_busy) w_state_nxt = S_DW_LO;
         S_DW_LO: begin
            if (!i_tx_busy) begin
               w_sent_nxt = r_sent_count + 16'd1;
               if (GAP_TICKS == 0) begin
                  w_state_nxt = S_IDLE;
               end else begin
                  w_gap_nxt   = GAP_LOAD;
                  w_state_nxt = S_GAP;
               end
            end
         end
         S_GAP: begin
            if (r_gap_cnt == '0) w_state_nxt = S_IDLE;
            else                 w_gap_nxt   = r_gap_cnt - 1'b1;
         end
         default: w_state_nxt = S_IDLE;
      endcase
      w_sbusy_nxt = (w_state_nxt != S_IDLE);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= S_IDLE;
         r_rr_ptr     <= '0;
         r_grant_id   <= '0;
         r_hold       <= '0;
         r_req_ready  <= '0;
         r_tx_start   <= 1'b0;
         r_tx_data    <= '0;
         r_sched_busy <= 1'b0;
         r_sent_count <= '0;
         r_gap_cnt    <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_rr_ptr     <= w_rr_nxt;
         r_grant_id   <= w_grant_nxt;
         r_hold       <= w_hold_nxt;
         r_req_ready  <= w_ready_nxt;
         r_tx_start   <= w_start_nxt;
         r_tx_data    <= w_txd_nxt;
         r_sched_busy <= w_sbusy_nxt;
         r_sent_count <= w_sent_nxt;
         r_gap_cnt    <= w_gap_nxt;
      end
   end

   assign o_req_ready  = r_req_ready;
   assign o_tx_start   = r_tx_start;
   assign o_tx_data    = r_tx_data;
   assign o_grant_id   = r_grant_id;
   assign o_sched_busy = r_sched_busy;
   assign o_sent_count = r_sent_count;

endmodule

// File: tb/tb_uart_tx_rr_sched.sv
// Directed bench for uart_tx_rr_sched: three instances (no header/gap 4, header/gap 4,
// no header/gap 10), each driving its own simple transmitter busy model.
module tb_uart_tx_rr_sched;

   localparam int BUSY_LEN = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  valid [3];
   logic [31:0] data  [3];
   logic [3:0]  ready [3];
   logic        start [3];
   logic [7:0]  txd   [3];
   logic        busy  [3];
   logic [1:0]  gnt   [3];
   logic        sbusy [3];
   logic [15:0] sent  [3];
   int          bcnt  [3];

   int cyc = 0;
   int n_checks = 0;
   int n_pass = 0;
   int t_req = 0;

   // event logs filled at the falling edge
   int         rd_n [3];
   int         st_n [3];
   int         fl_n [3];
   int         sb_n [3];
   logic [3:0] rd_v [3][32];
   int         rd_c [3][32];
   logic [7:0] st_d [3][32];
   logic [1:0] st_g [3][32];
   int         st_c [3][32];
   int         fl_c [3][32];
   int         sb_c [3][32];
   logic       busy_q [3];
   logic       sb_q   [3];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_tx_rr_sched #(.NUM_REQ(4), .HDR_EN(1'b0), .GAP_TICKS(4)) dut0 (
      .i_clk(clk), .i_rst(rst), .i_req_valid(valid[0]), .i_req_data(data[0]),
      .o_req_ready(ready[0]), .o_tx_start(start[0]), .o_tx_data(txd[0]),
      .i_tx_busy(busy[0]), .o_grant_id(gnt[0]), .o_sched_busy(sbusy[0]),
      .o_sent_count(sent[0]));

   uart_tx_rr_sched #(.NUM_REQ(4), .HDR_EN(1'b1), .GAP_TICKS(4)) dut1 (
      .i_clk(clk), .i_rst(rst), .i_req_valid(valid[1]), .i_req_data(data[1]),
      .o_req_ready(ready[1]), .o_tx_start(start[1]), .o_tx_data(txd[1]),
      .i_tx_busy(busy[1]), .o_grant_id(gnt[1]), .o_sched_busy(sbusy[1]),
      .o_sent_count(sent[1]));

   uart_tx_rr_sched #(.NUM_REQ(4), .HDR_EN(1'b0), .GAP_TICKS(10)) dut2 (
      .i_clk(clk), .i_rst(rst), .i_req_valid(valid[2]), .i_req_data(data[2]),
      .o_req_ready(ready[2]), .o_tx_start(start[2]), .o_tx_data(txd[2]),
      .i_tx_busy(busy[2]), .o_grant_id(gnt[2]), .o_sched_busy(sbusy[2]),
      .o_sent_count(sent[2]));

   // Transmitter model: busy rises the cycle after tx_start and stays high BUSY_LEN cycles.
   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (rst) begin
            busy[k] <= 1'b0;
            bcnt[k] <= 0;
         end else if (start[k]) begin
            busy[k] <= 1'b1;
            bcnt[k] <= BUSY_LEN - 1;
         end else if (busy[k]) begin
            if (bcnt[k] == 0) busy[k] <= 1'b0;
            else              bcnt[k] <= bcnt[k] - 1;
         end
      end
   end

   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (ready[k] != 4'b0 && rd_n[k] < 32) begin
            rd_v[k][rd_n[k]] = ready[k];
            rd_c[k][rd_n[k]] = cyc;
            rd_n[k]++;
         end
         if (start[k] === 1'b1 && st_n[k] < 32) begin
            st_d[k][st_n[k]] = txd[k];
            st_g[k][st_n[k]] = gnt[k];
            st_c[k][st_n[k]] = cyc;
            st_n[k]++;
         end
         if (busy_q[k] === 1'b1 && busy[k] === 1'b0 && fl_n[k] < 32) begin
            fl_c[k][fl_n[k]] = cyc;
            fl_n[k]++;
         end
         if (sb_q[k] === 1'b1 && sbusy[k] === 1'b0 && sb_n[k] < 32) begin
            sb_c[k][sb_n[k]] = cyc;
            sb_n[k]++;
         end
         busy_q[k] = busy[k];
         sb_q[k]   = sbusy[k];
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_logs();
      for (int k = 0; k < 3; k++) begin
         rd_n[k] = 0; st_n[k] = 0; fl_n[k] = 0; sb_n[k] = 0;
      end
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   // Present requests, optionally dropping each bit once served, until the DUT is idle again.
   task automatic serve(input int k, input logic [3:0] vmask, input logic [31:0] d,
                        input bit drop, input int nready);
      bit done = 1'b0;
      data[k]  = d;
      valid[k] = vmask;
      t_req    = cyc;
      for (int i = 0; i < 2000 && !done; i++) begin
         tick();
         if (drop) valid[k] = valid[k] & ~ready[k];
         if (rd_n[k] >= nready) valid[k] = '0;
         if (valid[k] == '0 && !sbusy[k] && !busy[k]) done = 1'b1;
      end
      valid[k] = '0;
      n_checks++;
      if (!done) $display("FAIL serve_timeout dut%0d: got busy after 2000 cycles, expected idle", k);
      else n_pass++;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if ({ready[k], start[k], txd[k], gnt[k], sbusy[k], sent[k]} !== 32'h0)
            $display("FAIL reset_values dut%0d: got rdy=%b st=%b d=%h g=%0d sb=%b n=%0d, expected all 0",
                     k, ready[k], start[k], txd[k], gnt[k], sbusy[k], sent[k]);
         else n_pass++;
      end
      rst = 1'b0;
      tick();
      tick();
      n_checks++;
      if (sbusy[0] !== 1'b0 || start[0] !== 1'b0)
         $display("FAIL idle_after_reset: got sb=%b st=%b, expected 0 0", sbusy[0], start[0]);
      else n_pass++;
   endtask

   task automatic test_single();
      clear_logs();
      serve(0, 4'b0010, 32'h0000_5A00, 1'b1, 1);
      n_checks++;
      if (rd_n[0] !== 1) $display("FAIL single_ready_count: got %0d, expected 1", rd_n[0]);
      else n_pass++;
      n_checks++;
      if (rd_v[0][0] !== 4'b0010) $display("FAIL single_ready_value: got %b, expected 0010", rd_v[0][0]);
      else n_pass++;
      n_checks++;
      if (rd_c[0][0] !== t_req + 2) $display("FAIL single_ready_latency: got %0d, expected %0d", rd_c[0][0], t_req + 2);
      else n_pass++;
      n_checks++;
      if (st_n[0] !== 1) $display("FAIL single_start_count: got %0d, expected 1", st_n[0]);
      else n_pass++;
      n_checks++;
      if (st_d[0][0] !== 8'h5A || st_g[0][0] !== 2'd1)
         $display("FAIL single_start_data: got data %h grant %0d, expected 5a grant 1", st_d[0][0], st_g[0][0]);
      else n_pass++;
      n_checks++;
      if (st_c[0][0] !== t_req + 3) $display("FAIL single_start_latency: got %0d, expected %0d", st_c[0][0], t_req + 3);
      else n_pass++;
      n_checks++;
      if (sent[0] !== 16'd1) $display("FAIL single_sent_count: got %0d, expected 1", sent[0]);
      else n_pass++;
      n_checks++;
      if (sb_n[0] !== 1 || sb_c[0][0] !== fl_c[0][0] + 5)
         $display("FAIL single_sched_busy_fall: got cycle %0d, expected %0d", sb_c[0][0], fl_c[0][0] + 5);
      else n_pass++;
   endtask

   task automatic test_header();
      clear_logs();
      serve(1, 4'b1000, 32'hC300_0000, 1'b1, 1);
      n_checks++;
      if (st_n[1] !== 2) $display("FAIL hdr_start_count: got %0d, expected 2", st_n[1]);
      else n_pass++;
      n_checks++;
      if (st_d[1][0] !== 8'hA3 || st_d[1][1] !== 8'hC3)
         $display("FAIL hdr_bytes: got %h %h, expected a3 c3", st_d[1][0], st_d[1][1]);
      else n_pass++;
      n_checks++;
      if (st_c[1][1] !== fl_c[1][0] + 2)
         $display("FAIL hdr_second_after_busy: got cycle %0d, expected %0d", st_c[1][1], fl_c[1][0] + 2);
      else n_pass++;
      n_checks++;
      if (sent[1] !== 16'd1 || st_g[1][1] !== 2'd3)
         $display("FAIL hdr_sent_grant: got sent %0d grant %0d, expected 1 3", sent[1], st_g[1][1]);
      else n_pass++;
   endtask

   task automatic test_fairness();
      logic [3:0] exp_v;
      logic [7:0] exp_d;
      apply_reset();
      clear_logs();
      serve(0, 4'b1111, 32'h1312_1110, 1'b0, 5);
      n_checks++;
      if (rd_n[0] !== 5 || st_n[0] !== 5)
         $display("FAIL rr_counts: got ready %0d start %0d, expected 5 5", rd_n[0], st_n[0]);
      else n_pass++;
      for (int i = 0; i < 5; i++) begin
         exp_v = 4'b0001 << (i % 4);
         exp_d = 8'h10 + 8'(i % 4);
         n_checks++;
         if (rd_v[0][i] !== exp_v || st_d[0][i] !== exp_d || st_g[0][i] !== 2'(i % 4))
            $display("FAIL rr_grant_%0d: got ready %b data %h grant %0d, expected %b %h %0d",
                     i, rd_v[0][i], st_d[0][i], st_g[0][i], exp_v, exp_d, i % 4);
         else n_pass++;
      end
   endtask

   task automatic test_gap();
      clear_logs();
      serve(2, 4'b0011, 32'h0000_2120, 1'b1, 2);
      n_checks++;
      if (st_n[2] !== 2 || st_d[2][0] !== 8'h20 || st_d[2][1] !== 8'h21)
         $display("FAIL gap_frames: got %0d starts %h %h, expected 2 starts 20 21", st_n[2], st_d[2][0], st_d[2][1]);
      else n_pass++;
      // busy is first sampled low one edge after the cycle it is observed low
      n_checks++;
      if (st_c[2][1] !== fl_c[2][0] + 1 + 13)
         $display("FAIL gap_second_start: got cycle %0d, expected %0d", st_c[2][1], fl_c[2][0] + 14);
      else n_pass++;
      n_checks++;
      if (sb_c[2][0] !== fl_c[2][0] + 1 + 10)
         $display("FAIL gap_idle_cycle: got cycle %0d, expected %0d", sb_c[2][0], fl_c[2][0] + 11);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      bit got = 1'b0;
      clear_logs();
      data[0]  = 32'h0000_7700;
      valid[0] = 4'b0010;
      for (int i = 0; i < 50 && !got; i++) begin
         tick();
         valid[0] = valid[0] & ~ready[0];
         if (st_n[0] >= 1) got = 1'b1;
      end
      valid[0] = '0;
      n_checks++;
      if (!got) $display("FAIL mid_start_timeout: got no tx_start, expected one");
      else n_pass++;
      tick();
      tick();
      rst = 1'b1;
      tick();
      n_checks++;
      if ({ready[0], start[0], txd[0], gnt[0], sbusy[0], sent[0]} !== 32'h0)
         $display("FAIL mid_reset_values: got rdy=%b st=%b d=%h g=%0d sb=%b n=%0d, expected all 0",
                  ready[0], start[0], txd[0], gnt[0], sbusy[0], sent[0]);
      else n_pass++;
      rst = 1'b0;
      repeat (10) tick();
      n_checks++;
      if (st_n[0] !== 1 || sent[0] !== 16'd0)
         $display("FAIL mid_abort: got starts %0d sent %0d, expected 1 0", st_n[0], sent[0]);
      else n_pass++;
      clear_logs();
      serve(0, 4'b1010, 32'h4400_3300, 1'b1, 2);
      n_checks++;
      if (rd_v[0][0] !== 4'b0010 || st_d[0][0] !== 8'h33)
         $display("FAIL mid_rr_ptr_reset: got ready %b data %h, expected 0010 33", rd_v[0][0], st_d[0][0]);
      else n_pass++;
   endtask

   task automatic test_wrap();
      clear_logs();
      force dut0.r_sent_count = 16'hFFFF;
      tick();
      release dut0.r_sent_count;
      tick();
      n_checks++;
      if (sent[0] !== 16'hFFFF) $display("FAIL wrap_preload: got %h, expected ffff", sent[0]);
      else n_pass++;
      serve(0, 4'b0001, 32'h0000_00EE, 1'b1, 1);
      n_checks++;
      if (sent[0] !== 16'h0000 || st_n[0] !== 1)
         $display("FAIL wrap_count: got %h after %0d frames, expected 0000 after 1", sent[0], st_n[0]);
      else n_pass++;
   endtask

   task automatic test_withdraw();
      clear_logs();
      data[0]  = 32'h00AB_0000;
      valid[0] = 4'b0100;
      tick();
      valid[0] = '0;
      repeat (10) tick();
      n_checks++;
      if (rd_n[0] !== 0 || st_n[0] !== 0)
         $display("FAIL withdraw_no_grant: got ready %0d start %0d, expected 0 0", rd_n[0], st_n[0]);
      else n_pass++;
      n_checks++;
      if (sb_n[0] !== 1 || sbusy[0] !== 1'b0 || gnt[0] !== 2'd0)
         $display("FAIL withdraw_state: got busy-falls %0d sb %b grant %0d, expected 1 0 0", sb_n[0], sbusy[0], gnt[0]);
      else n_pass++;
   endtask

   initial begin
      for (int k = 0; k < 3; k++) begin
         valid[k] = '0;
         data[k]  = '0;
         busy_q[k] = 1'b0;
         sb_q[k]   = 1'b0;
      end
      clear_logs();
      test_reset();
      test_single();
      test_header();
      test_fairness();
      test_gap();
      test_reset_mid();
      test_wrap();
      test_withdraw();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
